// File: rtl/hs32_mem_arbiter_if.sv
// rtl/hs32_mem_arbiter_if.sv - req/ack memory channel shared by fetch, execute and memory ports
//
// One transaction channel. The side that starts a transaction uses the
// master modport; the side that answers it uses the slave modport.
//   req   master->slave  request / strobe, held until ack
//   rw    master->slave  1 = write, 0 = read
//   addr  master->slave  32-bit word address
//   dtw   master->slave  32-bit write data
//   ack   slave->master  transaction done
//   dtr   slave->master  32-bit read data
interface hs32_mem_arbiter_if;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic        ack;
  logic [31:0] dtr;

  modport master (output req, rw, addr, dtw, input  ack, dtr);
  modport slave  (input  req, rw, addr, dtw, output ack, dtr);
endinterface

// File: rtl/hs32_mem_arbiter.sv
// rtl/hs32_mem_arbiter.sv - two-requester arbiter for the single 32-bit memory port
//
// Serialises fetch (read-only) and execute (load/store) requests onto one
// memory port, one strobe/ack transaction at a time: IDLE -> BUSY -> DONE.
// Macro HS32_ARB_RR_EN selects round-robin arbitration; without it execute
// always wins over fetch.
// Ports:
//   clk      system clock, posedge
//   reset_n  asynchronous active-low reset
//   flush    pipeline flush, cancels fetch requests/transactions
//   err      one-cycle pulse when a memory cycle is aborted by timeout
//   f_bus    fetch requester (slave side; rw/dtw ignored, always a read)
//   x_bus    execute requester (slave side)
//   m_bus    memory port (master side; req is the memory strobe)
// Parameters:
//   TIMEOUT  BUSY cycles without memory ack before abort, 0 disables
//   TW       timeout counter width, must hold TIMEOUT
module hs32_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  output logic                   err,
  hs32_mem_arbiter_if.slave      f_bus,
  hs32_mem_arbiter_if.slave      x_bus,
  hs32_mem_arbiter_if.master     m_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic GNT_F = 1'b0;
  localparam logic GNT_X = 1'b1;

  // Abort fires on the BUSY cycle whose increment would reach TIMEOUT.
  localparam int unsigned   TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_LAST_I);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          flushed_q, flushed_d;
  logic          m_stb_q, m_stb_d;
  logic          m_rw_q, m_rw_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_dtw_q, m_dtw_d;
  logic          f_ack_q, f_ack_d;
  logic          x_ack_q, x_ack_d;
  logic [31:0]   f_dtr_q, f_dtr_d;
  logic [31:0]   x_dtr_q, x_dtr_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
`ifdef HS32_ARB_RR_EN
  logic          rr_q, rr_d;
`endif

  logic f_ok;
  logic x_ok;
  logic pick_x;
  logic fetch_cancel;

  // The fetch port is read-only; its rw/dtw lines carry nothing we use.
  logic unused_fetch;
  assign unused_fetch = ^{f_bus.rw, f_bus.dtw};

  assign f_ok = f_bus.req & ~flush;
  assign x_ok = x_bus.req;

`ifdef HS32_ARB_RR_EN
  // On a tie the requester that did not win last time gets the port.
  assign pick_x = (x_ok && f_ok) ? (rr_q == GNT_F) : x_ok;
`else
  assign pick_x = x_ok;
`endif

  // A flush seen at any point of a fetch cycle cancels its ack, even if
  // flush has dropped again by the time memory answers.
  assign fetch_cancel = flushed_q | flush;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    flushed_d = flushed_q;
    m_stb_d   = m_stb_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_dtw_d   = m_dtw_q;
    f_dtr_d   = f_dtr_q;
    x_dtr_d   = x_dtr_q;
    cnt_d     = cnt_q;
    f_ack_d   = 1'b0;
    x_ack_d   = 1'b0;
    err_d     = 1'b0;
`ifdef HS32_ARB_RR_EN
    rr_d      = rr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        flushed_d = 1'b0;
        cnt_d     = '0;
        if (x_ok || f_ok) begin
          state_d = ST_BUSY;
          m_stb_d = 1'b1;
          if (pick_x) begin
            grant_d  = GNT_X;
            m_addr_d = x_bus.addr;
            m_rw_d   = x_bus.rw;
            m_dtw_d  = x_bus.dtw;
          end else begin
            grant_d  = GNT_F;
            m_addr_d = f_bus.addr;
            m_rw_d   = 1'b0;
            m_dtw_d  = '0;
          end
`ifdef HS32_ARB_RR_EN
          rr_d = pick_x ? GNT_X : GNT_F;
`endif
        end
      end

      ST_BUSY: begin
        if (grant_q == GNT_F && flush) begin
          flushed_d = 1'b1;
        end
        if (m_bus.ack) begin
          state_d = ST_DONE;
          m_stb_d = 1'b0;
          cnt_d   = '0;
          if (grant_q == GNT_X) begin
            if (!m_rw_q) begin
              x_dtr_d = m_bus.dtr;
            end
            x_ack_d = 1'b1;
          end else if (!fetch_cancel) begin
            f_dtr_d = m_bus.dtr;
            f_ack_d = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          if (cnt_q == TO_LAST) begin
            // Abort silently: the requester retries or gets flushed.
            state_d = ST_IDLE;
            m_stb_d = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end

      ST_DONE: begin
        // The ack pulse was registered on entry, so it is high for exactly
        // this cycle.
        state_d   = ST_IDLE;
        cnt_d     = '0;
        flushed_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        m_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_F;
      flushed_q <= 1'b0;
      m_stb_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_dtw_q   <= '0;
      f_ack_q   <= 1'b0;
      x_ack_q   <= 1'b0;
      f_dtr_q   <= '0;
      x_dtr_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef HS32_ARB_RR_EN
      rr_q      <= GNT_F;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      flushed_q <= flushed_d;
      m_stb_q   <= m_stb_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_dtw_q   <= m_dtw_d;
      f_ack_q   <= f_ack_d;
      x_ack_q   <= x_ack_d;
      f_dtr_q   <= f_dtr_d;
      x_dtr_q   <= x_dtr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef HS32_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign m_bus.req  = m_stb_q;
  assign m_bus.rw   = m_rw_q;
  assign m_bus.addr = m_addr_q;
  assign m_bus.dtw  = m_dtw_q;
  assign f_bus.ack  = f_ack_q;
  assign f_bus.dtr  = f_dtr_q;
  assign x_bus.ack  = x_ack_q;
  assign x_bus.dtr  = x_dtr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// tb/tb_hs32_mem_arbiter.sv - self-checking bench for hs32_mem_arbiter
module tb_hs32_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic err;

  always #5 clk = ~clk;

  hs32_mem_arbiter_if f_bus ();
  hs32_mem_arbiter_if x_bus ();
  hs32_mem_arbiter_if m_bus ();

  hs32_mem_arbiter #(.TIMEOUT(4), .TW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .err     (err),
    .f_bus   (f_bus),
    .x_bus   (x_bus),
    .m_bus   (m_bus)
  );

  typedef struct {
    bit          is_x;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] f_model = '0;
  logic [31:0] x_model = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every requester ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (f_bus.ack || x_bus.ack)) begin
      total++;
      if (f_bus.ack && x_bus.ack) begin
        bad++;
        $display("FAIL ack_overlap: got f_ack=1 x_ack=1 want at most one");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got f_ack=%0b x_ack=%0b want none", f_bus.ack, x_bus.ack);
      end else begin
        e = sb.pop_front();
        if (x_bus.ack !== e.is_x || (e.is_x ? x_bus.dtr : f_bus.dtr) !== e.data) begin
          bad++;
          $display("FAIL scoreboard_ack: got x=%0b data=%h want x=%0b data=%h",
                   x_bus.ack, e.is_x ? x_bus.dtr : f_bus.dtr, e.is_x, e.data);
        end
      end
    end
  end

  task automatic req_f(input logic [31:0] addr);
    f_bus.req  = 1'b1;
    f_bus.addr = addr;
    f_bus.rw   = 1'b1;          // garbage: fetch must always read
    f_bus.dtw  = 32'hFFFF_FFFF; // garbage: fetch never writes
  endtask

  task automatic req_x(input bit rw, input logic [31:0] addr, input logic [31:0] dtw);
    x_bus.req  = 1'b1;
    x_bus.rw   = rw;
    x_bus.addr = addr;
    x_bus.dtw  = dtw;
  endtask

  // Called in an IDLE cycle with the request(s) already driven. Memory acks
  // on BUSY cycle d+1. Leaves the bench in the following IDLE cycle with the
  // winner's request dropped.
  task automatic txn(input string name, input bit is_x, input logic [31:0] addr,
                     input bit rw, input logic [31:0] dtw, input logic [31:0] data,
                     input int d, input bit exp_ack);
    int stb_n = 0;
    int bus_n = 0;
    bit exp_rw;
    logic [31:0] exp_dtw;
    exp_rw  = is_x ? rw : 1'b0;
    exp_dtw = is_x ? dtw : 32'h0;
    if (exp_ack) begin
      if (is_x) begin
        if (!rw) x_model = data;
        sb.push_back('{1'b1, x_model});
      end else begin
        f_model = data;
        sb.push_back('{1'b0, f_model});
      end
    end
    tick();
    for (int i = 0; i <= d; i++) begin
      if (m_bus.req === 1'b1) stb_n++;
      if (m_bus.addr !== addr || m_bus.rw !== exp_rw || m_bus.dtw !== exp_dtw) bus_n++;
      if (i == d) begin
        m_bus.ack = 1'b1;
        m_bus.dtr = data;
      end
      tick();
    end
    m_bus.ack = 1'b0;
    m_bus.dtr = 32'h5A5A_5A5A;
    total++;
    if (stb_n != d + 1) begin
      bad++;
      $display("FAIL %s_stb_cycles: got %0d want %0d", name, stb_n, d + 1);
    end
    total++;
    if (bus_n != 0) begin
      bad++;
      $display("FAIL %s_bus_fields: got %0d bad cycles want 0 (addr=%h rw=%0b dtw=%h)",
               name, bus_n, m_bus.addr, m_bus.rw, m_bus.dtw);
    end
    total++;
    if ({m_bus.req, f_bus.ack, x_bus.ack} !== {1'b0, exp_ack && !is_x, exp_ack && is_x}) begin
      bad++;
      $display("FAIL %s_done: got stb=%0b f_ack=%0b x_ack=%0b want stb=0 f_ack=%0b x_ack=%0b",
               name, m_bus.req, f_bus.ack, x_bus.ack, exp_ack && !is_x, exp_ack && is_x);
    end
    total++;
    if (f_bus.dtr !== f_model || x_bus.dtr !== x_model) begin
      bad++;
      $display("FAIL %s_dtr: got f=%h x=%h want f=%h x=%h",
               name, f_bus.dtr, x_bus.dtr, f_model, x_model);
    end
    tick();
    if (is_x) x_bus.req = 1'b0;
    else f_bus.req = 1'b0;
    total++;
    if ({f_bus.ack, x_bus.ack, err} !== 3'b000) begin
      bad++;
      $display("FAIL %s_ack_pulse: got f_ack=%0b x_ack=%0b err=%0b want 0 0 0",
               name, f_bus.ack, x_bus.ack, err);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({m_bus.req, m_bus.rw, f_bus.ack, x_bus.ack, err} !== 5'b0 ||
        m_bus.addr !== 32'h0 || m_bus.dtw !== 32'h0 ||
        f_bus.dtr !== 32'h0 || x_bus.dtr !== 32'h0) begin
      bad++;
      $display("FAIL %s: got stb=%0b rw=%0b f_ack=%0b x_ack=%0b err=%0b addr=%h dtw=%h f_dtr=%h x_dtr=%h want all 0",
               name, m_bus.req, m_bus.rw, f_bus.ack, x_bus.ack, err,
               m_bus.addr, m_bus.dtw, f_bus.dtr, x_bus.dtr);
    end
  endtask

  task automatic test_reset();
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    tick();
    tick();
    total++;
    if (m_bus.req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got stb=%0b want 0", m_bus.req);
    end
  endtask

  task automatic test_fetch_read();
    req_f(32'h10);
    txn("fetch_read", 1'b0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
  endtask

  task automatic test_exec_write();
    req_x(1'b1, 32'h40, 32'h1234);
    txn("exec_write", 1'b1, 32'h40, 1'b1, 32'h1234, 32'hFFFF_0000, 2, 1'b1);
  endtask

  task automatic test_priority();
    req_f(32'h14);
    req_x(1'b0, 32'h44, 32'h0);
`ifdef HS32_ARB_RR_EN
    // Previous grant went to execute, so fetch wins the tie.
    txn("prio_first_f", 1'b0, 32'h14, 1'b0, 32'h0, 32'h0BAD_F00D, 1, 1'b1);
    txn("prio_second_x", 1'b1, 32'h44, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
`else
    txn("prio_first_x", 1'b1, 32'h44, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
    txn("prio_second_f", 1'b0, 32'h14, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 1'b1);
`endif
  endtask

  task automatic test_flush();
    req_f(32'h20);
    tick();
    total++;
    if (m_bus.req !== 1'b1 || m_bus.addr !== 32'h20) begin
      bad++;
      $display("FAIL flush_grant: got stb=%0b addr=%h want 1 00000020", m_bus.req, m_bus.addr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    f_bus.req = 1'b0;
    m_bus.ack = 1'b1;
    m_bus.dtr = 32'hBAD0_BAD0;
    tick();
    m_bus.ack = 1'b0;
    total++;
    if (f_bus.ack !== 1'b0 || f_bus.dtr !== f_model) begin
      bad++;
      $display("FAIL flush_suppress: got f_ack=%0b f_dtr=%h want 0 %h", f_bus.ack, f_bus.dtr, f_model);
    end
    tick();
    // Flush held in IDLE keeps fetch from being granted.
    req_f(32'h24);
    flush = 1'b1;
    tick();
    total++;
    if (m_bus.req !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_block: got stb=%0b want 0", m_bus.req);
    end
    flush = 1'b0;
    txn("flush_next", 1'b0, 32'h24, 1'b0, 32'h0, 32'h1357_9BDF, 1, 1'b1);
  endtask

  task automatic test_timeout();
    int n = 0;
    int err_early = 0;
    req_x(1'b0, 32'h90, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (m_bus.req !== 1'b1) break;
      if (err !== 1'b0) err_early++;
      n++;
      tick();
    end
    total++;
    if (n != 4 || err_early != 0) begin
      bad++;
      $display("FAIL timeout_stb: got %0d cycles (early err %0d) want 4 (0)", n, err_early);
    end
    total++;
    if ({err, f_bus.ack, x_bus.ack} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_err: got err=%0b f_ack=%0b x_ack=%0b want 1 0 0", err, f_bus.ack, x_bus.ack);
    end
    x_bus.req = 1'b0;
    tick();
    total++;
    if ({err, m_bus.req} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_idle: got err=%0b stb=%0b want 0 0", err, m_bus.req);
    end
  endtask

  task automatic test_reset_mid();
    req_x(1'b1, 32'hA0, 32'h77);
    tick();
    total++;
    if (m_bus.req !== 1'b1 || m_bus.rw !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got stb=%0b rw=%0b want 1 1", m_bus.req, m_bus.rw);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    x_bus.req = 1'b0;
    f_model = '0;
    x_model = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    total++;
    if ({m_bus.req, f_bus.ack, x_bus.ack} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_idle: got stb=%0b f_ack=%0b x_ack=%0b want 0 0 0",
               m_bus.req, f_bus.ack, x_bus.ack);
    end
  endtask

  task automatic test_back_to_back();
    req_f(32'h30);
    txn("b2b_fetch", 1'b0, 32'h30, 1'b0, 32'h0, 32'h2468_ACE0, 0, 1'b1);
    req_x(1'b0, 32'h50, 32'h0);
    txn("b2b_exec", 1'b1, 32'h50, 1'b0, 32'h0, 32'h8765_4321, 0, 1'b1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    f_bus.req = 1'b0; f_bus.rw = 1'b0; f_bus.addr = '0; f_bus.dtw = '0;
    x_bus.req = 1'b0; x_bus.rw = 1'b0; x_bus.addr = '0; x_bus.dtw = '0;
    m_bus.ack = 1'b0; m_bus.dtr = '0;
    tick();
    tick();
    test_reset();
    test_fetch_read();
    test_exec_write();
    test_priority();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
